// File: rtl/titan_wb_arbiter.sv
// rtl/titan_wb_arbiter.sv - merges pipeline writeback and buffered MDU results onto one register-file write port
module titan_wb_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_rd,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    output logic        hazard,
    output logic [4:0]  waddr_rd,
    output logic [31:0] wdata_rd,
    output logic        we
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    fifo_rd   [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   busy;

    logic          pipe_take;
    logic          push;
    logic          pop;
    logic [31:0]   set_mask;
    logic [31:0]   clr_mask;

    assign pipe_take = pipe_valid & (pipe_rd != 5'd0);
    assign mdu_ready = ~rst & (count != CW'(FIFO_DEPTH));
    // x0 results are accepted from the MDU but never stored
    assign push      = mdu_valid & mdu_ready & (mdu_rd != 5'd0);
    assign pop       = ~pipe_take & (count != '0);
    assign set_mask  = (mdu_issue && mdu_issue_rd != 5'd0) ? (32'd1 << mdu_issue_rd) : 32'd0;
    assign clr_mask  = pop ? (32'd1 << fifo_rd[rd_ptr]) : 32'd0;

    function automatic logic addr_hit(input logic [4:0] a, input logic [31:0] b,
                                      input logic w, input logic [4:0] wa);
        return (a != 5'd0) && (b[a] || (w && wa == a));
    endfunction

    assign hazard = addr_hit(dec_rs1, busy, we, waddr_rd) |
                    addr_hit(dec_rs2, busy, we, waddr_rd) |
                    addr_hit(dec_rd,  busy, we, waddr_rd);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= mdu_rd;
            fifo_data[wr_ptr] <= mdu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            busy     <= '0;
            we       <= 1'b0;
            waddr_rd <= '0;
            wdata_rd <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // set after clear so a re-issue to the popped register stays busy
            busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
            if (pipe_take) begin
                we       <= 1'b1;
                waddr_rd <= pipe_rd;
                wdata_rd <= pipe_data;
            end else if (pop) begin
                we       <= 1'b1;
                waddr_rd <= fifo_rd[rd_ptr];
                wdata_rd <= fifo_data[rd_ptr];
            end else begin
                we <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_titan_wb_arbiter.sv
// tb/tb_titan_wb_arbiter.sv - directed and random checks of titan_wb_arbiter against a queue-based model
module tb_titan_wb_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_rd;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        hazard;
    logic [4:0]  waddr_rd;
    logic [31:0] wdata_rd;
    logic        we;

    int checks = 0;
    int failures = 0;

    // reference state: results waiting for the port, registers with pending writes, the port itself
    logic [36:0] m_q[$];
    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    always #5 clk = ~clk;

    titan_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .hazard(hazard),
        .waddr_rd(waddr_rd), .wdata_rd(wdata_rd), .we(we)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_pending(input logic [4:0] a);
        return (a != 5'd0) && (m_busy[a] || (m_we && m_waddr == a));
    endfunction

    function automatic bit m_hazard();
        return m_pending(dec_rs1) || m_pending(dec_rs2) || m_pending(dec_rd);
    endfunction

    function automatic bit m_ready();
        return !rst && (m_q.size() < DEPTH);
    endfunction

    task automatic check_model();
        chk("we", we, m_we);
        chk("waddr_rd", waddr_rd, m_waddr);
        chk("wdata_rd", wdata_rd, m_wdata);
        chk("mdu_ready", mdu_ready, m_ready());
        chk("hazard", hazard, m_hazard());
    endtask

    task automatic check_hazard();
        #1;
        chk("hazard_dec", hazard, m_hazard());
    endtask

    task automatic tick();
        logic [36:0] e;
        bit acc;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_busy = '0;
            m_we = 0; m_waddr = '0; m_wdata = '0;
        end else begin
            acc = mdu_valid && (m_q.size() < DEPTH) && mdu_rd != 5'd0;
            if (pipe_valid && pipe_rd != 5'd0) begin
                m_we = 1; m_waddr = pipe_rd; m_wdata = pipe_data;
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_we = 1; m_waddr = e[36:32]; m_wdata = e[31:0];
                m_busy[e[36:32]] = 1'b0;
            end else begin
                m_we = 0;
            end
            if (mdu_issue && mdu_issue_rd != 5'd0) m_busy[mdu_issue_rd] = 1'b1;
            if (acc) m_q.push_back({mdu_rd, mdu_data});
        end
        #1;
        check_model();
    endtask

    task automatic idle();
        pipe_valid = 0; pipe_rd = '0; pipe_data = '0;
        mdu_issue = 0; mdu_issue_rd = '0;
        mdu_valid = 0; mdu_rd = '0; mdu_data = '0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    endtask

    initial begin
        logic saw9;
        m_busy = '0; m_we = 0; m_waddr = '0; m_wdata = '0;
        idle();
        rst = 1;

        // reset then idle
        tick();
        tick();
        chk("ready_in_rst", mdu_ready, 1'b0);
        rst = 0;
        #1;
        chk("ready_after_rst", mdu_ready, 1'b1);
        chk("we_after_rst", we, 1'b0);
        for (int i = 0; i < 3; i++) begin
            dec_rs1 = 5'($urandom); dec_rs2 = 5'($urandom); dec_rd = 5'($urandom);
            check_hazard();
            chk("hazard_idle", hazard, 1'b0);
        end
        idle();
        tick();

        // pipeline write
        pipe_valid = 1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
        tick();
        idle();
        dec_rs2 = 5'd5;
        check_hazard();
        chk("pipe_we", we, 1'b1);
        chk("pipe_waddr", waddr_rd, 32'd5);
        chk("pipe_wdata", wdata_rd, 32'hDEADBEEF);
        chk("pipe_hazard", hazard, 1'b1);
        tick();
        chk("pipe_we_done", we, 1'b0);
        chk("pipe_hazard_done", hazard, 1'b0);

        // MDU result collides with three pipeline writes
        idle();
        mdu_issue = 1; mdu_issue_rd = 5'd7;
        tick();
        idle();
        dec_rs1 = 5'd7;
        pipe_valid = 1; pipe_rd = 5'd3; pipe_data = 32'h33;
        mdu_valid = 1; mdu_rd = 5'd7; mdu_data = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            tick();
            mdu_valid = 0;
            chk("coll_pipe_addr", waddr_rd, 32'd3);
            chk("coll_hazard", hazard, 1'b1);
        end
        pipe_valid = 0;
        tick();
        chk("coll_mdu_we", we, 1'b1);
        chk("coll_mdu_addr", waddr_rd, 32'd7);
        chk("coll_mdu_data", wdata_rd, 32'h12345678);
        chk("coll_hazard_last", hazard, 1'b1);
        tick();
        chk("coll_hazard_clear", hazard, 1'b0);

        // FIFO fills while the pipeline holds the port
        idle();
        pipe_valid = 1; pipe_rd = 5'd4; pipe_data = 32'h44;
        mdu_valid = 1;
        for (int i = 0; i < 3; i++) begin
            mdu_rd = 5'(10 + i); mdu_data = 32'(32'hA0 + i);
            #1;
            chk("full_ready", mdu_ready, (i < 2) ? 1'b1 : 1'b0);
            tick();
        end
        idle();
        tick();
        chk("drain0_addr", waddr_rd, 32'd10);
        chk("drain0_ready", mdu_ready, 1'b1);
        tick();
        chk("drain1_addr", waddr_rd, 32'd11);
        tick();
        chk("drain_idle", we, 1'b0);

        // x0 handling: queued entry drains behind pipe_rd=0, x0 MDU result dropped
        pipe_valid = 1; pipe_rd = 5'd4; mdu_valid = 1; mdu_rd = 5'd13; mdu_data = 32'h13;
        tick();
        pipe_rd = 5'd0; mdu_rd = 5'd0; mdu_data = 32'hBAD;
        mdu_issue = 1; mdu_issue_rd = 5'd0;
        tick();
        chk("x0_drain_addr", waddr_rd, 32'd13);
        idle();
        tick();
        chk("x0_no_write", we, 1'b0);
        chk("x0_busy", dut.busy, 32'd0);

        // reset mid-flight drops queued rd=9 and its busy bit
        mdu_issue = 1; mdu_issue_rd = 5'd9;
        tick();
        idle();
        pipe_valid = 1; pipe_rd = 5'd4; mdu_valid = 1; mdu_rd = 5'd9; mdu_data = 32'h99;
        tick();
        idle();
        rst = 1;
        tick();
        rst = 0;
        dec_rd = 5'd9;
        saw9 = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (we && waddr_rd == 5'd9) saw9 = 1;
            chk("rst_hazard9", hazard, 1'b0);
        end
        chk("rst_no_write9", saw9, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            pipe_valid   = ($urandom_range(0, 2) == 0);
            pipe_rd      = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            pipe_data    = $urandom;
            mdu_issue    = $urandom_range(0, 1);
            mdu_issue_rd = 5'($urandom);
            mdu_valid    = $urandom_range(0, 1);
            mdu_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            mdu_data     = $urandom;
            dec_rs1      = 5'($urandom);
            dec_rs2      = 5'($urandom);
            dec_rd       = 5'($urandom);
            check_hazard();
            chk("rand_ready", mdu_ready, m_ready());
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
